mac_neuron_acc: RTL and testbench
=================================

// Module: mac_neuron_acc
// PURPOSE
//  Sequential multiply-accumulate neuron: consumes N_INPUTS (activation, weight) pairs over a valid/ready
//  stream, one product per cycle, on top of a preloaded bias. Emits the signed 2*WIDTH accumulator that
//  feeds the ReLU activation stage (activation input port is 2*WIDTH signed). Producer side of that link.
// PARAMETERS
//  WIDTH     8  signed bit width of activation and weight; product/out_acc are 2*WIDTH
//  N_INPUTS  4  pairs accumulated per neuron evaluation (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  start      in   1        pulse: load bias, begin evaluation (honoured only in IDLE)
//  bias       in   2*WIDTH  signed bias, same fixed-point scale as a*w product, sampled on start
//  in_valid   in   1        act/wgt pair valid
//  in_ready   out  1        pair accepted when in_valid & in_ready
//  in_act     in   WIDTH    signed activation
//  in_wgt     in   WIDTH    signed weight
//  out_valid  out  1        out_acc valid; held until out_ready
//  out_ready  in   1        downstream accepts out_acc
//  out_acc    out  2*WIDTH  signed accumulated sum (to ReLU)
//  busy       out  1        high in ACCUM or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, count=0; in_ready=0, out_valid=0, out_acc=0, busy=0 on next clk edge.
//  - Internal ACC_W = 2*WIDTH + clog2(N_INPUTS)+1, so no internal overflow; bias sign-extended to ACC_W.
//  - FSM IDLE -> ACCUM: on start; acc<=sext(bias), count<=0. Other inputs ignored in IDLE.
//  - ACCUM: in_ready=1. On accept: acc<=acc+sext(in_act*in_wgt) (full signed 2*WIDTH product);
//    count++. Accept with count==N_INPUTS-1 -> DONE. in_valid gaps stall; count unchanged.
//  - DONE: in_ready=0, out_valid=1, out_acc=narrow(acc) registered, stable while out_ready=0.
//    out_valid & out_ready -> IDLE (out_valid low next cycle). start in ACCUM/DONE ignored.
//  - Latency: out_valid rises the cycle after the last pair is accepted; best case N_INPUTS+1 cycles
//    from start to out_valid. Throughput: one evaluation per N_INPUTS+2 cycles (no start/out overlap).
//  - N_INPUTS=1: first accept goes straight to DONE.
//  - rst mid-ACCUM/DONE: discard partial sum, outputs to reset values; no output is emitted.
//  - Extreme operands (-2^(W-1) * -2^(W-1)) are exact in 2*WIDTH product; narrowing handles the sum.
// CONFIGURATION
//  MAC_SAT_EN defined: narrow() clamps acc to [-2^(2W-1), 2^(2W-1)-1]; out-of-range sums saturate.
//  MAC_SAT_EN undefined: narrow() = acc[2*WIDTH-1:0] (two's-complement wrap), no clamp logic.
// STRUCTURE
//  - Shared include nn_pkg.vh: state encodings (ST_IDLE=0, ST_ACCUM=1, ST_DONE=2), clog2 function,
//    ACC_W derivation, common by all nn blocks.
//  - One sub-module: acc_narrow (ACC_W -> 2*WIDTH, saturating or wrapping per MAC_SAT_EN), reusable by
//    other accumulators. FSM, counter, MAC datapath stay in mac_neuron_acc.
// TESTING  (WIDTH=8, N_INPUTS=4 unless noted)
//  1 start bias=0; pairs act{1,2,3,4} wgt{1,1,1,1} back-to-back -> out_valid 1 cycle after 4th accept,
//    out_acc=10; bias=-20 same pairs -> out_acc=-10.
//  2 act{-128 x4} wgt{127 x4}, bias=0 -> sum -65024: MAC_SAT_EN out_acc=-32768; undefined out_acc=512.
//  3 in_valid toggled 1,0,0,1,0,1,1 with act{5,6,7,8} wgt{2,2,2,2} -> out_acc=52, accepts only when valid.
//  4 out_ready held 0 for 3 cycles in DONE -> out_acc/out_valid stable, in_ready=0, start pulse ignored;
//    out_ready=1 -> IDLE next cycle, busy=0.
//  5 rst asserted after 2 accepts -> next cycle in_ready=0,out_valid=0,out_acc=0; fresh start with
//    test-1 pairs -> out_acc=10 (no residue).
//  6 N_INPUTS=1: start bias=3, pair (-7,9) -> out_acc=-60 one cycle after accept.

Source files
------------

// File: rtl/mac_neuron_acc_pkg.sv
// Shared definitions for the nn accumulator blocks: FSM state encoding and
// accumulator width derivation helpers.
package mac_neuron_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Smallest r with 2**r >= v (0 for v <= 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Accumulator wide enough that bias plus n full products can never overflow.
   function automatic int acc_width(input int width, input int n);
      return 2*width + clog2(n) + 1;
   endfunction

endpackage

// File: rtl/acc_narrow.sv
// Narrows a wide signed accumulator to OUT_W bits.
// Build option MAC_SAT_EN: when defined, out-of-range values clamp to the
// OUT_W signed limits; when undefined, the value wraps (low bits kept).
module acc_narrow #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

`ifdef MAC_SAT_EN
   logic [IN_W-OUT_W:0] hi;
   logic                fits;

   // Value fits when all bits from the output sign bit upward agree.
   always_comb begin
      hi   = din[IN_W-1:OUT_W-1];
      fits = (&hi) | ~(|hi);
      if (fits)
         dout = din[OUT_W-1:0];
      else if (din[IN_W-1])
         dout = {1'b1, {(OUT_W-1){1'b0}}};
      else
         dout = {1'b0, {(OUT_W-1){1'b1}}};
   end
`else
   logic unused_hi;

   // Two's-complement wrap; discarded upper bits intentionally unused.
   always_comb begin
      dout      = din[OUT_W-1:0];
      unused_hi = ^din[IN_W-1:OUT_W];
   end
`endif

endmodule

// File: rtl/mac_neuron_acc.sv
// Sequential multiply-accumulate neuron: bias plus N_INPUTS act*wgt products,
// one pair per cycle over valid/ready, result handed to the ReLU stage.
// Build option MAC_SAT_EN selects saturating (defined) or wrapping output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; bias loaded into acc on start
// ST_ACCUM | in_ready high, one product added per accepted pair
// ST_DONE  | out_valid high, out_acc held until out_ready
module mac_neuron_acc
   import mac_neuron_acc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N_INPUTS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [2*WIDTH-1:0] bias,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH-1:0]   in_act,
   input  logic signed [WIDTH-1:0]   in_wgt,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [2*WIDTH-1:0] out_acc,
   output logic                      busy
);

   localparam int ACC_W = acc_width(WIDTH, N_INPUTS);
   localparam int EXT_W = ACC_W - 2*WIDTH;
   localparam int CNT_W = (N_INPUTS > 1) ? clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

   state_t                    state, state_nxt;
   logic signed [ACC_W-1:0]   acc, acc_sum;
   logic [CNT_W-1:0]          count;
   logic signed [2*WIDTH-1:0] prod, narrowed;
   logic                      accept, last;

   assign prod    = in_act * in_wgt;
   assign acc_sum = acc + {{EXT_W{prod[2*WIDTH-1]}}, prod};
   assign accept  = in_valid & in_ready;
   assign last    = (count == LAST);

   // The value registered into out_acc is the narrowed post-add sum, so the
   // output is ready the cycle after the final accept.
   acc_narrow #(
      .IN_W  (ACC_W),
      .OUT_W (2*WIDTH)
   ) u_narrow (
      .din  (acc_sum),
      .dout (narrowed)
   );

   // State register plus accumulator, counter and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         acc     <= '0;
         count   <= '0;
         out_acc <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc   <= {{EXT_W{bias[2*WIDTH-1]}}, bias};
                  count <= '0;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc   <= acc_sum;
                  count <= count + 1'b1;
                  if (last) out_acc <= narrowed;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept && last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mac_neuron_acc.sv
// Directed bench for mac_neuron_acc (WIDTH=8, N_INPUTS=4, plus an N_INPUTS=1 instance).
module tb_mac_neuron_acc;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0, start1 = 1'b0;
   logic signed [15:0] bias = '0, bias1 = '0;
   logic               in_valid = 1'b0, in_valid1 = 1'b0;
   logic signed [7:0]  in_act = '0, in_wgt = '0, in_act1 = '0, in_wgt1 = '0;
   logic               out_ready = 1'b0, out_ready1 = 1'b0;
   logic               in_ready, out_valid, busy;
   logic               in_ready1, out_valid1, busy1;
   logic signed [15:0] out_acc, out_acc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_neuron_acc #(.WIDTH(8), .N_INPUTS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .busy(busy)
   );

   mac_neuron_acc #(.WIDTH(8), .N_INPUTS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .bias(bias1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_act(in_act1), .in_wgt(in_wgt1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_acc(out_acc1), .busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic do_start(input logic signed [15:0] b);
      bias  = b;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic feed(input int a, input int w);
      in_valid = 1'b1;
      in_act   = 8'(a);
      in_wgt   = 8'(w);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset
      step(); step();
      rst = 1'b0;
      chk1 ("rst_in_ready", in_ready, 1'b0);
      chk1 ("rst_out_valid", out_valid, 1'b0);
      chk1 ("rst_busy", busy, 1'b0);
      chk16("rst_out_acc", out_acc, 16'd0);

      // Test 1: bias 0, pairs 1..4 x 1
      do_start(16'sd0);
      chk1("t1_in_ready", in_ready, 1'b1);
      chk1("t1_busy", busy, 1'b1);
      feed(1, 1); feed(2, 1); feed(3, 1);
      chk1("t1_no_valid_early", out_valid, 1'b0);
      feed(4, 1);
      chk1 ("t1_out_valid", out_valid, 1'b1);
      chk1 ("t1_in_ready_done", in_ready, 1'b0);
      chk16("t1_out_acc", out_acc, 16'd10);
      drain();
      chk1("t1_idle_valid", out_valid, 1'b0);
      chk1("t1_idle_busy", busy, 1'b0);

      // Test 1b: bias -20
      do_start(-16'sd20);
      feed(1, 1); feed(2, 1); feed(3, 1); feed(4, 1);
      chk1 ("t1b_out_valid", out_valid, 1'b1);
      chk16("t1b_out_acc", out_acc, 16'hFFF6);
      drain();

      // Test 2: extreme operands, sum -65024
      do_start(16'sd0);
      feed(-128, 127); feed(-128, 127); feed(-128, 127); feed(-128, 127);
      chk1("t2_out_valid", out_valid, 1'b1);
`ifdef MAC_SAT_EN
      chk16("t2_out_acc_sat", out_acc, 16'h8000);
`else
      chk16("t2_out_acc_wrap", out_acc, 16'd512);
`endif
      drain();

      // Test 3: in_valid pattern 1,0,0,1,0,1,1; start pulsed during a gap must be ignored
      do_start(16'sd0);
      feed(5, 2);
      in_act = 8'sd99; in_wgt = 8'sd99;
      start = 1'b1; bias = 16'sd1000;
      step();
      start = 1'b0;
      chk1("t3_gap_ready", in_ready, 1'b1);
      step();
      feed(6, 2);
      step();
      chk1("t3_not_done_yet", out_valid, 1'b0);
      feed(7, 2);
      chk1("t3_not_done_3", out_valid, 1'b0);
      feed(8, 2);
      chk1 ("t3_out_valid", out_valid, 1'b1);
      chk16("t3_out_acc", out_acc, 16'd52);

      // Test 4: hold in DONE with out_ready low; start ignored
      for (int i = 0; i < 3; i++) begin
         start = (i == 1);
         bias  = 16'sd77;
         step();
         chk1 ("t4_hold_valid", out_valid, 1'b1);
         chk1 ("t4_hold_ready", in_ready, 1'b0);
         chk16("t4_hold_acc", out_acc, 16'd52);
      end
      start = 1'b0;
      drain();
      chk1("t4_idle_valid", out_valid, 1'b0);
      chk1("t4_idle_busy", busy, 1'b0);
      chk1("t4_idle_in_ready", in_ready, 1'b0);

      // Test 5: reset mid-accumulation, then clean evaluation
      do_start(16'sd500);
      feed(10, 10); feed(10, 10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk1 ("t5_rst_in_ready", in_ready, 1'b0);
      chk1 ("t5_rst_out_valid", out_valid, 1'b0);
      chk16("t5_rst_out_acc", out_acc, 16'd0);
      chk1 ("t5_rst_busy", busy, 1'b0);
      do_start(16'sd0);
      feed(1, 1); feed(2, 1); feed(3, 1); feed(4, 1);
      chk1 ("t5_out_valid", out_valid, 1'b1);
      chk16("t5_out_acc", out_acc, 16'd10);
      drain();

      // Test 6: N_INPUTS=1, bias 3, pair (-7, 9) -> -60
      bias1  = 16'sd3;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk1("t6_in_ready", in_ready1, 1'b1);
      in_valid1 = 1'b1; in_act1 = -8'sd7; in_wgt1 = 8'sd9;
      step();
      in_valid1 = 1'b0;
      chk1 ("t6_out_valid", out_valid1, 1'b1);
      chk16("t6_out_acc", out_acc1, 16'hFFC4);
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      chk1("t6_idle_valid", out_valid1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
